// File: rtl/sd_cmd_serializer.sv
// sd_cmd_serializer: SD CMD-line token serializer (start, tx bit, index, arg, CRC7, end), MSB first.
// Ports: clk, resetn (async active-low), tick (bit-rate enable),
//        cmd_valid/cmd_ready handshake with cmd_index[5:0]/cmd_arg[31:0],
//        cmd_out/cmd_oe serial line, busy (not IDLE), done (one-clk end pulse).
// Optional: define SD_CMD_NCC_GAP_EN to hold off 8 tick edges in GAP after each token.
module sd_cmd_serializer (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CRC
`ifdef SD_CMD_NCC_GAP_EN
        , GAP
`endif
    } state_t;
    state_t      state;
    logic [39:0] sh;
    logic [5:0]  cnt;
    logic [6:0]  crc;
    logic [6:0]  crc_n;
    logic        fb;
    // serial CRC7 (x^7+x^3+1) fed with the bit currently on the line, sh[39]
    assign fb        = sh[39] ^ crc[6];
    assign crc_n     = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            crc     <= '0;
            cmd_out <= 1'b1;
            cmd_oe  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    sh      <= {2'b01, cmd_index, cmd_arg};
                    crc     <= '0;
                    cnt     <= 6'd39;
                    cmd_out <= 1'b0;
                    cmd_oe  <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: if (tick) begin
                    crc <= crc_n;
                    sh  <= {sh[38:0], 1'b0};
                    if (cnt == 6'd0) begin
                        cmd_out <= crc_n[6];
                        cnt     <= 6'd7;
                        state   <= CRC;
                    end else begin
                        cmd_out <= sh[38];
                        cnt     <= cnt - 6'd1;
                    end
                end
                // cnt 7..2 shifts out CRC7[5:0], cnt 1 drives the end bit, cnt 0 releases the line
                CRC: if (tick) begin
                    if (cnt == 6'd0) begin
                        cmd_out <= 1'b1;
                        cmd_oe  <= 1'b0;
                        done    <= 1'b1;
`ifdef SD_CMD_NCC_GAP_EN
                        cnt     <= 6'd7;
                        state   <= GAP;
`else
                        state   <= IDLE;
`endif
                    end else begin
                        cmd_out <= (cnt == 6'd1) ? 1'b1 : crc[5];
                        crc     <= {crc[5:0], 1'b0};
                        cnt     <= cnt - 6'd1;
                    end
                end
`ifdef SD_CMD_NCC_GAP_EN
                GAP: if (tick) begin
                    if (cnt == 6'd0) state <= IDLE;
                    else cnt <= cnt - 6'd1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_serializer.sv
// tb_sd_cmd_serializer: table-driven and randomized checks of sd_cmd_serializer against a CRC7 long-division model.
module tb_sd_cmd_serializer;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tick = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = '0;
    logic [31:0] cmd_arg = '0;
    logic        cmd_out;
    logic        cmd_oe;
    logic        busy;
    logic        done;
    int          n_pass = 0;
    int          n_tot = 0;

    sd_cmd_serializer dut (
        .clk(clk), .resetn(resetn), .tick(tick), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_arg(cmd_arg), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Token = message followed by remainder of message*x^7 divided by x^7+x^3+1, then end bit.
    function automatic logic [47:0] ref_tok(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        logic [46:0] r;
        m = {2'b01, idx, arg};
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r = r ^ (47'h89 << (i - 7));
        return {m, r[6:0], 1'b1};
    endfunction

    // Sends one command with a tick every per clks and checks stream, timing and handshake.
    task automatic send(input logic [5:0] idx, input logic [31:0] arg, input int per,
                        input logic [47:0] exp, input string nm);
        logic [47:0] tok;
        int oe_cnt, dn_cnt, dn_at, hold_err, t, j;
        tok = '0; oe_cnt = 0; dn_cnt = 0; dn_at = -1; hold_err = 0; t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        chk({nm, " ready_before"}, 64'(cmd_ready), 64'd1);
        cmd_index = idx; cmd_arg = arg; cmd_valid = 1'b1; tick = 1'($urandom_range(0, 1));
        @(posedge clk);
        for (int k = 1; k <= 48 * per + 1; k++) begin
            @(negedge clk);
            j = k - 1;
            if (k == 1) begin
                cmd_valid = 1'b0;
                chk({nm, " busy_flags"}, {62'd0, cmd_ready, busy}, 64'd1);
            end
            cmd_index = 6'($urandom); cmd_arg = $urandom;
            if (cmd_oe) oe_cnt++;
            if (done) begin dn_cnt++; dn_at = j; end
            if (j < 48 * per) begin
                if (j % per == 0) tok[47 - j / per] = cmd_out;
                else if (cmd_out !== tok[47 - j / per]) hold_err++;
            end
            if (j == 48 * per) chk({nm, " line_released"}, {62'd0, cmd_oe, cmd_out}, 64'd1);
            tick = ((k % per) == 0);
            @(posedge clk);
        end
        chk({nm, " token"}, 64'(tok), 64'(exp));
        chk({nm, " done_at"}, 64'(dn_at), 64'(48 * per));
        chk({nm, " done_pulses"}, 64'(dn_cnt), 64'd1);
        chk({nm, " oe_clks"}, 64'(oe_cnt), 64'(48 * per));
        if (per > 1) chk({nm, " bit_hold_errs"}, 64'(hold_err), 64'd0);
    endtask

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        int          per;
        logic [47:0] tok;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int n, m;
        logic [5:0]  ri;
        logic [31:0] ra;
        vecs[0] = '{6'd0,  32'h0000_0000, 1, 48'h4000_0000_0095};
        vecs[1] = '{6'd8,  32'h0000_01AA, 1, 48'h4800_0001_AA87};
        vecs[2] = '{6'd17, 32'h0000_0000, 4, 48'h5100_0000_0055};
        vecs[3] = '{6'd55, 32'h0000_0000, 2, 48'h7700_0000_0065};

        repeat (2) @(negedge clk);
        chk("rst cmd_out", 64'(cmd_out), 64'd1);
        chk("rst cmd_oe", 64'(cmd_oe), 64'd0);
        chk("rst ready_busy", {62'd0, cmd_ready, busy}, 64'd2);
        chk("rst done", 64'(done), 64'd0);
        resetn = 1'b1;

        for (int i = 0; i < 4; i++)
            send(vecs[i].idx, vecs[i].arg, vecs[i].per, vecs[i].tok, $sformatf("vec%0d", i));

        // reset in the middle of a CMD8 token
        @(negedge clk);
        cmd_index = 6'd8; cmd_arg = 32'h1AA; cmd_valid = 1'b1; tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid oe_before_rst", 64'(cmd_oe), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst line", {62'd0, cmd_oe, cmd_out}, 64'd1);
        chk("mid_rst flags", {61'd0, cmd_ready, busy, done}, 64'd4);
        @(negedge clk);
        resetn = 1'b1;
        send(6'd0, 32'h0, 1, 48'h4000_0000_0095, "post_rst");

        // back-to-back with cmd_valid held high
        @(negedge clk);
        cmd_index = 6'd0; cmd_arg = 32'h0; cmd_valid = 1'b1; tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (cmd_oe && n < 100) begin @(negedge clk); n++; end
        chk("b2b oe_clks", 64'(n), 64'd48);
        m = 0;
        while (!cmd_oe && m < 100) begin @(negedge clk); m++; end
`ifndef SD_CMD_NCC_GAP_EN
        chk("b2b idle_clks", 64'(m), 64'd1);
`endif
        chk("b2b start_bit", 64'(cmd_out), 64'd0);
        cmd_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            ri = 6'($urandom);
            ra = $urandom;
            send(ri, ra, int'($urandom_range(1, 3)), ref_tok(ri, ra), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/sd_cmd_serializer.md
SD_CMD_SERIALIZER -- requirements
Module: sd_cmd_serializer

Interface
REQ-001: clk  input  1  system clock; all state changes occur on its rising edge.
REQ-002: resetn  input  1  asynchronous, active-low reset.
REQ-003: tick  input  1  SD bit-rate enable; each CMD-line bit advances on a clk edge where tick=1.
REQ-004: cmd_valid  input  1  a command request is present on cmd_index/cmd_arg.
REQ-005: cmd_ready  output  1  serializer can accept a command.
REQ-006: cmd_index  input  6  command index, CMD0..CMD63.
REQ-007: cmd_arg  input  32  command argument.
REQ-008: cmd_out  output  1  serial CMD-line data, MSB first.
REQ-009: cmd_oe  output  1  CMD-line output enable; 1 while this block drives the line.
REQ-010: busy  output  1  high whenever the block is not in IDLE.
REQ-011: done  output  1  one-clk pulse when the end bit has completed.

Function
REQ-012: States: IDLE, SHIFT, CRC, GAP. GAP exists only when the macro in REQ-027 is defined.
REQ-013: cmd_ready=1 only in IDLE; cmd_ready=0 in every other state.
REQ-014: A command is accepted on the clk edge where cmd_valid=1 and cmd_ready=1; tick does not affect acceptance.
REQ-015: Token format, 48 bits, MSB first: start bit 0, transmission bit 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], end bit 1.
REQ-016: At the acceptance edge, the block latches the first 40 bits, clears CRC7 to 0, and enters SHIFT. cmd_oe goes to 1 and cmd_out goes to 0 (the start bit) at that same edge.
REQ-017: In SHIFT, each tick edge advances cmd_out to the next latched bit. The 6-bit counter runs 39 down to 0.
REQ-018: CRC7 uses polynomial x^7+x^3+1. It is updated serially on each bit as that bit is replaced, over bits 47..8 only.
REQ-019: The tick edge that retires bit 8 moves the block to CRC and drives CRC7[6] onto cmd_out. The next 6 tick edges shift out CRC7[5:0]. The following tick edge drives the end bit 1.
REQ-020: The tick edge after the end bit does all of the following: cmd_oe=0, cmd_out=1, done=1 for exactly one clk, and the block enters GAP (macro defined) or IDLE (macro undefined).
REQ-021: Every bit, including the first and last, is held for exactly one tick interval. With tick tied to 1, the block is busy for exactly 48 clk cycles from acceptance to done.
REQ-022: tick=0 freezes all state, counters, CRC and outputs. done never pulses on a non-tick edge.
REQ-023: cmd_valid and the input buses are ignored outside IDLE. A request presented while busy stays pending until cmd_ready is 1.
REQ-024: When cmd_oe=0, cmd_out=1 (idle-high line level).

Reset
REQ-025: When resetn=0, asynchronously and at any time including mid-token: state=IDLE, cmd_out=1, cmd_oe=0, done=0, busy=0, cmd_ready=1, counters=0, CRC=0.
REQ-026: After resetn deasserts, a command is accepted on the first clk edge with cmd_valid=1. A token interrupted by reset is never resumed.

Configuration
REQ-027: Macro SD_CMD_NCC_GAP_EN. When defined, after done the block stays in GAP for 8 tick edges with cmd_oe=0, busy=1 and cmd_ready=0, then returns to IDLE. When undefined, the block returns to IDLE on the same edge that pulses done, and cmd_ready=1 on the next cycle.

Verification
REQ-028: tick=1, CMD0 with arg 0x00000000 -> serial stream 0x400000000095; done pulses 48 clks after acceptance.
REQ-029: tick=1, CMD8 with arg 0x000001AA -> serial stream 0x48000001AA87; cmd_oe is high for exactly 48 clks.
REQ-030: tick asserted every 4th clk, CMD17 with arg 0 -> each bit is held for 4 clks; last byte is 0x55; done is a single-clk pulse.
REQ-031: resetn pulsed low at bit 20 of CMD8 -> cmd_oe=0 and cmd_out=1 immediately. A following CMD0 then produces a clean 0x400000000095.
REQ-032: Back-to-back requests (cmd_valid held high) -> with SD_CMD_NCC_GAP_EN defined there are exactly 8 idle ticks between the end bit and the next start bit; without it, the next start bit follows after 1 clk in IDLE.
REQ-033: cmd_index and cmd_arg changed while busy -> the transmitted token is unchanged from the values latched at acceptance.
